// File: rtl/wavegen_pkg.sv
// Shared types for the waveform capture path: sample format and capture FSM states.
// No logic; imported by the capture top and its RAM.
package wavegen_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ARMED,
        POST,
        DONE
    } capture_state_t;

endpackage

// File: rtl/capture_ram.sv
// Purpose: DEPTH x SAMPLE_W simple dual-port sample store, one write port, one read port.
// Latency: read data registered, 1 clk after rd_addr; writes land on the clk edge.
// Backpressure: none, both ports accept every clk.
module capture_ram
    import wavegen_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_vld,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [SAMPLE_W-1:0] wr_dat,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [SAMPLE_W-1:0] rd_dat
);

    logic [SAMPLE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Only the output register is reset; the array keeps whatever it last held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat <= '0;
        end else begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/wave_capture.sv
// Purpose: scope-style triggered capture of the DAC sample stream with pre-trigger history and auto-trigger.
// Latency: one write per i_cs; o_done one clk after the final POST write; readout 1 clk after i_rd_addr.
// Backpressure: none; samples arriving in IDLE/DONE or coincident with i_arm are dropped.
module wave_capture
    import wavegen_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 8,
    parameter int PRE_TRIG = 32,
    parameter int AUTO_TO  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       i_sample,
    input  logic              i_cs,
    input  logic              i_arm,
    input  logic [15:0]       i_trig_level,
    input  logic              i_trig_slope,
    input  logic              i_auto,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [15:0]       o_rd_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_auto
);

    localparam int POST_LEN = DEPTH - PRE_TRIG;
    localparam int CNT_W    = $clog2(AUTO_TO + DEPTH + 1);

    capture_state_t    state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] trig_ptr;
    logic [ADDR_W-1:0] rd_phys;
    sample_t           cur;
    sample_t           lvl;
    sample_t           prev;
    logic              prev_vld;
    logic              auto_q;
    logic              wr_vld;
    logic              level_hit;
    logic              auto_hit;
    logic              trig_set;
    logic              auto_set;

    assign cur     = sample_t'(i_sample);
    assign lvl     = sample_t'(i_trig_level);
    assign cnt_inc = cnt + CNT_W'(1);
    assign o_busy  = (state == PRE) || (state == ARMED) || (state == POST);
    assign o_done  = (state == DONE);
    assign o_auto  = auto_q;
    assign wr_vld  = i_cs && !i_arm && o_busy;

    assign level_hit = prev_vld && (i_trig_slope ? ((prev > lvl) && (cur <= lvl))
                                                 : ((prev < lvl) && (cur >= lvl)));
    assign auto_hit  = i_auto && (cnt_inc == CNT_W'(AUTO_TO));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        trig_set  = 1'b0;
        auto_set  = 1'b0;
        if (i_arm) begin
            state_nxt = PRE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                PRE: begin
                    if (PRE_TRIG == 0) begin
                        state_nxt = ARMED;
                    end else if (wr_vld) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CNT_W'(PRE_TRIG)) begin
                            state_nxt = ARMED;
                            cnt_nxt   = '0;
                        end
                    end
                end
                ARMED: begin
                    if (wr_vld) begin
                        if (i_auto) begin
                            cnt_nxt = cnt_inc;
                        end
                        // A genuine level crossing takes precedence over the timeout flag.
                        if (level_hit || auto_hit) begin
                            trig_set  = 1'b1;
                            auto_set  = !level_hit;
                            cnt_nxt   = CNT_W'(1);
                            state_nxt = (POST_LEN == 1) ? DONE : POST;
                        end
                    end
                end
                POST: begin
                    if (wr_vld) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CNT_W'(POST_LEN)) begin
                            state_nxt = DONE;
                            cnt_nxt   = '0;
                        end
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            wr_ptr   <= '0;
            trig_ptr <= '0;
            prev     <= '0;
            prev_vld <= 1'b0;
            auto_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (i_arm) begin
                wr_ptr   <= '0;
                prev_vld <= 1'b0;
                auto_q   <= 1'b0;
            end else begin
                if (wr_vld) begin
                    wr_ptr   <= wr_ptr + ADDR_W'(1);
                    prev     <= cur;
                    prev_vld <= 1'b1;
                end
                if (trig_set) begin
                    trig_ptr <= wr_ptr;
                    auto_q   <= auto_set;
                end
            end
        end
    end

    // Logical address 0 is the oldest pre-trigger sample; wrap is implicit in ADDR_W.
    assign rd_phys = trig_ptr - ADDR_W'(PRE_TRIG) + i_rd_addr;

    capture_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_vld  (wr_vld),
        .wr_addr (wr_ptr),
        .wr_dat  (i_sample),
        .rd_addr (rd_phys),
        .rd_dat  (o_rd_data)
    );

endmodule

// File: tb/tb_wave_capture.sv
// Randomized scoreboard bench for wave_capture: a history-based capture model predicts status per sample and readout data.
`timescale 1ns/1ps
module tb_wave_capture;
    import wavegen_pkg::*;

    localparam int DEPTH    = 256;
    localparam int ADDR_W   = 8;
    localparam int PRE_TRIG = 32;
    localparam int AUTO_TO  = 4096;
    localparam int POST_LEN = DEPTH - PRE_TRIG;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [15:0]       i_sample = '0;
    logic              i_cs = 1'b0;
    logic              i_arm = 1'b0;
    logic [15:0]       i_trig_level = '0;
    logic              i_trig_slope = 1'b0;
    logic              i_auto = 1'b0;
    logic [ADDR_W-1:0] i_rd_addr = '0;
    logic [15:0]       o_rd_data;
    logic              o_busy;
    logic              o_done;
    logic              o_auto;

    always #5 clk = ~clk;

    wave_capture #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .PRE_TRIG(PRE_TRIG), .AUTO_TO(AUTO_TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_sample(i_sample), .i_cs(i_cs), .i_arm(i_arm),
        .i_trig_level(i_trig_level), .i_trig_slope(i_trig_slope), .i_auto(i_auto),
        .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .o_busy(o_busy),
        .o_done(o_done), .o_auto(o_auto)
    );

    int tests = 0;
    int fails = 0;

    // Scoreboard queues and issue tracking
    int         exp_rd[$];
    int         exp_addr[$];
    logic [1:0] exp_st[$];
    logic       rd_req = 1'b0;
    logic       rd_pend = 1'b0;
    logic       cs_pend = 1'b0;

    // Reference model: everything accepted since the last arm
    int hist[$];
    int m_trig = -1;
    bit m_auto = 0;
    bit m_done = 0;
    bit m_cap = 0;
    int m_lvl = 0;
    bit m_slope = 0;
    bit m_auto_en = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        rd_pend <= rd_req;
        cs_pend <= i_cs;
    end

    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_rd.size() == 0) begin
                check("rd_queue_empty", 1, 0);
            end else begin
                int e;
                int a;
                e = exp_rd.pop_front();
                a = exp_addr.pop_front();
                check($sformatf("rd[%0d]", a), int'(sample_t'(o_rd_data)), e);
            end
        end
        if (cs_pend) begin
            if (exp_st.size() == 0) begin
                check("status_queue_empty", 1, 0);
            end else begin
                logic [1:0] s;
                s = exp_st.pop_front();
                check("status{done,busy}", int'({o_done, o_busy}), int'(s));
            end
        end
    end

    function automatic int gen(input int kind, input int n);
        case (kind)
            0: return -1000 + 10 * n;
            1: return 500;
            2: begin
                if (n < 5)       return -100;
                else if (n < 40) return 100;
                else if (n < 60) return -50;
                else             return 200 + n;
            end
            3: begin
                if (n < 32)       return 20;
                else if (n == 32) return 10;
                else if (n == 33) return 0;
                else if (n == 34) return -5;
                else if (n == 35) return 10;
                else if (n == 36) return 0;
                else              return int'($urandom_range(200, 0)) - 100;
            end
            default: return int'($urandom_range(400, 0)) - 200;
        endcase
    endfunction

    task automatic model_arm(input int lvl, input bit slope, input bit auto_en);
        hist.delete();
        m_trig    = -1;
        m_auto    = 0;
        m_done    = 0;
        m_cap     = 1;
        m_lvl     = lvl;
        m_slope   = slope;
        m_auto_en = auto_en;
    endtask

    task automatic do_arm(input int lvl, input bit slope, input bit auto_en, input bit with_cs, input int cs_val);
        @(negedge clk);
        i_trig_level = 16'(lvl);
        i_trig_slope = slope;
        i_auto       = auto_en;
        i_arm        = 1'b1;
        if (with_cs) begin
            i_sample = 16'(cs_val);
            i_cs     = 1'b1;
        end
        model_arm(lvl, slope, auto_en);
        if (with_cs) exp_st.push_back(2'b01);
        @(negedge clk);
        i_arm = 1'b0;
        i_cs  = 1'b0;
        check("arm_busy", int'(o_busy), 1);
        check("arm_done", int'(o_done), 0);
        check("arm_auto", int'(o_auto), 0);
    endtask

    task automatic send_sample(input int v, input int gap);
        @(negedge clk);
        i_sample = 16'(v);
        i_cs     = 1'b1;
        if (m_cap && !m_done) begin
            int n;
            bit lvl_hit;
            hist.push_back(v);
            n = hist.size() - 1;
            if (m_trig < 0 && n >= PRE_TRIG) begin
                lvl_hit = m_slope ? (hist[n-1] > m_lvl && hist[n] <= m_lvl)
                                  : (hist[n-1] < m_lvl && hist[n] >= m_lvl);
                if (lvl_hit || (m_auto_en && (n - PRE_TRIG + 1) == AUTO_TO)) begin
                    m_trig = n;
                    m_auto = !lvl_hit;
                end
            end
            if (m_trig >= 0 && n == m_trig + POST_LEN - 1) m_done = 1;
        end
        exp_st.push_back({m_done, m_cap && !m_done});
        @(negedge clk);
        i_cs = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic feed(input int kind, input int stop_at, input int gap_lo, input int gap_hi);
        int lim;
        lim = 5000;
        while (!m_done && (stop_at < 0 || hist.size() < stop_at) && lim > 0) begin
            send_sample(gen(kind, hist.size()), int'($urandom_range(gap_hi, gap_lo)));
            lim--;
        end
    endtask

    task automatic issue_read(input int addr, input int expv);
        @(negedge clk);
        i_rd_addr = ADDR_W'(addr);
        rd_req    = 1'b1;
        exp_rd.push_back(expv);
        exp_addr.push_back(addr);
    endtask

    task automatic end_reads();
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic finish_capture(input string tag);
        int off;
        if (!m_done) begin
            check({tag, "_timeout_no_done"}, 0, 1);
            return;
        end
        repeat (3) send_sample(gen(4, 0), 1);
        check({tag, "_done"}, int'(o_done), 1);
        check({tag, "_busy"}, int'(o_busy), 0);
        check({tag, "_auto"}, int'(o_auto), int'(m_auto));
        off = int'($urandom_range(255, 0));
        for (int k = 0; k < DEPTH; k++) begin
            int a;
            a = (k * 37 + off) % DEPTH;
            issue_read(a, hist[m_trig - PRE_TRIG + a]);
        end
        end_reads();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_auto", int'(o_auto), 0);
        check("rst_rd_data", int'(o_rd_data), 0);
        rst_n = 1'b1;

        // Ramp through zero, one strobe per 8 clk
        do_arm(0, 0, 0, 0, 0);
        feed(0, -1, 6, 6);
        finish_capture("ramp");
        issue_read(0, -320);
        issue_read(32, 0);
        issue_read(255, 2230);
        end_reads();

        // Crossing during PRE must be ignored; the later one triggers
        do_arm(0, 0, 0, 0, 0);
        feed(2, -1, 0, 3);
        finish_capture("pre_ignore");
        issue_read(32, 260);
        end_reads();

        // Falling trigger, no retrigger on the following samples
        do_arm(0, 1, 0, 0, 0);
        feed(3, -1, 0, 2);
        finish_capture("falling");
        issue_read(31, 10);
        issue_read(32, 0);
        issue_read(33, -5);
        end_reads();

        // Constant input never crosses; auto-trigger must fire
        do_arm(0, 1, 1, 0, 0);
        feed(1, -1, 0, 1);
        finish_capture("auto");
        check("auto_flag", int'(o_auto), 1);

        // Async reset in the middle of POST
        do_arm(0, 0, 0, 0, 0);
        feed(0, 110, 0, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midpost_rst_busy", int'(o_busy), 0);
        check("midpost_rst_done", int'(o_done), 0);
        check("midpost_rst_auto", int'(o_auto), 0);
        check("midpost_rst_rd_data", int'(o_rd_data), 0);
        m_cap  = 0;
        m_done = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) send_sample(gen(4, 0), 1);
        check("idle_busy", int'(o_busy), 0);

        // Re-arm mid-POST with a coincident strobe; that sample is dropped
        do_arm(0, 0, 0, 0, 0);
        feed(0, 115, 0, 2);
        do_arm(0, 0, 1, 1, 777);
        feed(4, -1, 0, 3);
        finish_capture("rearm");

        // Random data, random level and slope
        for (int r = 0; r < 4; r++) begin
            int lvl;
            bit slope;
            lvl   = int'($urandom_range(100, 0)) - 50;
            slope = 1'($urandom_range(1, 0));
            do_arm(lvl, slope, 1, 0, 0);
            feed(4, -1, 0, 3);
            finish_capture($sformatf("rand%0d", r));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_rd.size() + exp_st.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wave_capture.md
Name: wave_capture

Overview:
Triggered capture buffer that sits directly downstream of the codec-side sample mux and records the 16-bit signed stream sent to the DAC, qualified by the sample_req[1] strobe. Provides scope-style capture: pre-trigger history, level/slope trigger, optional auto-trigger, then a random-access read port for a display or readout stage. One write per sample strobe; reads are independent of capture.

Parameters:
DEPTH, 256, buffer length in samples (power of two)
ADDR_W, 8, log2(DEPTH)
PRE_TRIG, 32, samples kept before the trigger sample (must be < DEPTH)
AUTO_TO, 4096, armed samples without a trigger before an auto-trigger is forced

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_sample  in  16  signed sample, valid when i_cs=1
i_cs  in  1  sample strobe, one clk wide (sample_req[1])
i_arm  in  1  start/restart capture; acts on every clk it is high
i_trig_level  in  16  signed trigger threshold
i_trig_slope  in  1  0 = rising, 1 = falling
i_auto  in  1  enable auto-trigger timeout
i_rd_addr  in  ADDR_W  logical read address, 0 = oldest pre-trigger sample
o_rd_data  out  16  sample at i_rd_addr, 1-clk latency
o_busy  out  1  capture in progress (PRE/ARMED/POST)
o_done  out  1  buffer holds a complete capture
o_auto  out  1  last capture was auto-triggered

Behaviour:
- Clock and reset: single clock clk; reset asynchronous, active-low (rst_n).
- Reset values: state IDLE; o_busy=0, o_done=0, o_auto=0, o_rd_data=0; write pointer, counters, trigger pointer and prev-valid flag cleared. RAM contents are not reset.
- States: IDLE, PRE, ARMED, POST, DONE.
- i_arm=1 in any state: go to PRE next clk. Clear counters, prev-valid, o_done and o_auto. Write pointer goes to 0. Arm wins over a coincident i_cs, and that sample is dropped.
- Every i_cs in PRE/ARMED/POST: write i_sample at the write pointer, increment the pointer mod DEPTH, set prev=i_sample, set prev-valid.
- i_cs in IDLE/DONE: ignored.
- PRE: after PRE_TRIG writes, go to ARMED. Trigger conditions in PRE are ignored.
- ARMED, rising trigger: prev-valid && prev < level && cur >= level (signed compare).
- ARMED, falling trigger: prev-valid && prev > level && cur <= level.
- ARMED, on trigger: the sample is written, trig_ptr = its address, go to POST next clk.
- Auto-trigger: if i_auto=1, count i_cs in ARMED. When the count reaches AUTO_TO, force a trigger on that sample and set o_auto=1.
- POST: the trigger sample counts as 1. After DEPTH-PRE_TRIG-1 further writes, go to DONE on the clk after the last write. o_done=1 and o_busy=0 from that clk.
- DONE: hold until i_arm.
- Readout: physical address = (trig_ptr - PRE_TRIG + i_rd_addr) mod DEPTH. o_rd_data is registered, 1-clk latency. Data is defined only while o_done=1; otherwise it is stable RAM content with no meaning.
- o_busy = state in {PRE, ARMED, POST}.

Decomposition:
- Package wavegen_pkg holds:
  - capture_state_t enum (IDLE, PRE, ARMED, POST, DONE)
  - SAMPLE_W=16
  - the signed sample typedef sample_t
- Sub-module capture_ram: simple dual-port RAM, one write port, one registered read port, DEPTH x SAMPLE_W, no reset on the array.

Test Plan:
1. Reset asserted mid-POST -> all outputs 0 immediately (async). Afterwards, i_cs pulses with no arm -> stays IDLE, o_busy=0.
2. Arm, level=0, rising, ramp s_n=-1000+10n, one i_cs per 8 clk -> trigger at n=100. o_done rises one clk after the write of n=323. Reads: rd_addr 0 -> -320, rd_addr 32 -> 0, rd_addr 255 -> 2230.
3. Constant input 500, level 0, falling, i_auto=1 -> no level trigger. Forced trigger on the 4096th ARMED sample, o_auto=1, o_done after 223 further samples.
4. Input crossing 0 upward at n=5, and again at n=60 (rising, PRE_TRIG=32) -> n=5 crossing ignored (PRE). Trigger at n=60, and rd_addr 32 returns the n=60 value.
5. i_arm pulsed mid-POST, coincident with i_cs -> that sample is not written, state PRE, o_done stays 0. A full new capture completes correctly.
6. Falling-edge case: prev=10, cur=0, level=0, falling -> trigger. Then prev=0, cur=-5 -> no retrigger (prev not > level), and no double trigger within one capture.
